ga_crossover_unit: RTL and testbench

Parametrised crossover stage for the genetic-algorithm datapath. It takes two parent genes split into `NSEG` equal segments and produces two complementary children. Uniform, single-point or two-point crossover is selected per transaction; per-segment LFSRs can be reseeded. The block sits between parent selection and mutation, uses valid/ready handshakes on both sides with one register stage, and keeps a saturating count of crossover events.

---
 rtl/ga_crossover_unit_if.sv | 26 ++
 rtl/ga_crossover_unit.sv | 190 +++++++++++++++++++
 tb/tb_ga_crossover_unit.sv | 320 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ga_crossover_unit_if.sv
// Valid/ready bundle around the crossover stage: parents and per-transaction controls in, children out.
interface ga_crossover_unit_if #(
  parameter int GENE_W = 32
) ();
  logic [1:0]        mode;
  logic [7:0]        co_prob;
  logic              bias;
  logic              in_valid;
  logic              in_ready;
  logic [GENE_W-1:0] parent0;
  logic [GENE_W-1:0] parent1;
  logic              out_valid;
  logic              out_ready;
  logic [GENE_W-1:0] child0;
  logic [GENE_W-1:0] child1;

  modport master (
    output mode, co_prob, bias, in_valid, parent0, parent1, out_ready,
    input  in_ready, out_valid, child0, child1
  );

  modport slave (
    input  mode, co_prob, bias, in_valid, parent0, parent1, out_ready,
    output in_ready, out_valid, child0, child1
  );
endinterface

// File: rtl/ga_crossover_unit.sv
// Crossover stage of the GA datapath: builds a per-segment swap mask from per-segment LFSRs and
// emits two complementary children through a single registered valid/ready stage.
module ga_crossover_unit #(
  parameter int          GENE_W = 32,
  parameter int          SEG_W  = 8,
  parameter logic [15:0] SEED   = 16'hACE1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               seed_load,
  input  logic [15:0]        seed_in,
  output logic [15:0]        xover_count,
  ga_crossover_unit_if.slave bus
);
  localparam int NSEG = GENE_W / SEG_W;
  localparam int LG   = $clog2(NSEG);

  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  state_t            state_r;
  state_t            state_nxt_s;
  logic [15:0]       lfsr_r [NSEG];
  logic [NSEG-1:0]   mask_s;
  logic [LG-1:0]     cut0_s;
  logic [LG-1:0]     cut1_s;
  logic [LG-1:0]     lo_s;
  logic [LG-1:0]     hi_s;
  logic              hit2_s;
  logic              accept_s;
  logic              in_ready_s;
  logic [GENE_W-1:0] src_a_s;
  logic [GENE_W-1:0] src_b_s;
  logic [GENE_W-1:0] nxt0_s;
  logic [GENE_W-1:0] nxt1_s;
  logic [GENE_W-1:0] child0_r;
  logic [GENE_W-1:0] child1_r;
  logic [15:0]       xover_count_r;

  // Fibonacci LFSR, taps 16,14,13,11, shifting toward the LSB.
  function automatic logic [15:0] lfsr_step(input logic [15:0] cur);
    return {cur[0] ^ cur[2] ^ cur[3] ^ cur[5], cur[15:1]};
  endfunction

  // Each segment gets a decorrelated seed; the all-zero lock-up state is never loaded.
  function automatic logic [15:0] seed_of(input logic [15:0] base, input int idx);
    logic [15:0] s;
    s = base ^ (16'(idx) * 16'h1F35);
    if (s == 16'h0000) begin
      s = 16'h0001;
    end else begin
      s = s;
    end
    return s;
  endfunction

  function automatic logic hit(input logic [7:0] x, input logic [7:0] thr);
    return (x < thr) || (thr == 8'hFF);
  endfunction

  assign in_ready_s = (state_r == ST_EMPTY) || bus.out_ready;
  assign accept_s   = bus.in_valid && in_ready_s;

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = (state_r == ST_FULL);
  assign bus.child0    = child0_r;
  assign bus.child1    = child1_r;
  assign xover_count   = xover_count_r;

  // Swap mask from the current (pre-advance) LFSR outputs and the live transaction controls.
  always_comb begin
    mask_s = '0;
    cut0_s = lfsr_r[0][LG-1:0];
    cut1_s = lfsr_r[1][LG-1:0];
    lo_s   = (cut0_s < cut1_s) ? cut0_s : cut1_s;
    hi_s   = (cut0_s < cut1_s) ? cut1_s : cut0_s;
    hit2_s = hit(lfsr_r[2][7:0], bus.co_prob);
    case (bus.mode)
      2'd0: begin
        for (int i = 0; i < NSEG; i++) begin
          mask_s[i] = hit(lfsr_r[i][7:0], bus.co_prob);
        end
      end
      2'd1: begin
        for (int i = 0; i < NSEG; i++) begin
          mask_s[i] = hit2_s && (LG'(i) >= cut0_s);
        end
      end
      2'd2: begin
        for (int i = 0; i < NSEG; i++) begin
          mask_s[i] = hit2_s && (LG'(i) >= lo_s) && (LG'(i) < hi_s);
        end
      end
      default: begin
        mask_s = '0;
      end
    endcase
  end

  // Segment steering; child1 always takes whatever child0 did not.
  always_comb begin
    src_a_s = bus.bias ? bus.parent1 : bus.parent0;
    src_b_s = bus.bias ? bus.parent0 : bus.parent1;
    nxt0_s  = '0;
    nxt1_s  = '0;
    for (int i = 0; i < NSEG; i++) begin
      nxt0_s[i*SEG_W +: SEG_W] = mask_s[i] ? src_b_s[i*SEG_W +: SEG_W] : src_a_s[i*SEG_W +: SEG_W];
      nxt1_s[i*SEG_W +: SEG_W] = mask_s[i] ? src_a_s[i*SEG_W +: SEG_W] : src_b_s[i*SEG_W +: SEG_W];
    end
  end

  // Output-slot occupancy: refilled on accept, drained when downstream takes it with nothing new.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_EMPTY: begin
        if (accept_s) begin
          state_nxt_s = ST_FULL;
        end else begin
          state_nxt_s = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (accept_s) begin
          state_nxt_s = ST_FULL;
        end else if (bus.out_ready) begin
          state_nxt_s = ST_EMPTY;
        end else begin
          state_nxt_s = ST_FULL;
        end
      end
      default: begin
        state_nxt_s = ST_EMPTY;
      end
    endcase
  end

  // Occupancy state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_EMPTY;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // LFSR bank: a reseed wins over the accept-driven advance in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NSEG; i++) begin
        lfsr_r[i] <= seed_of(SEED, i);
      end
    end else if (seed_load) begin
      for (int i = 0; i < NSEG; i++) begin
        lfsr_r[i] <= seed_of(seed_in, i);
      end
    end else if (accept_s) begin
      for (int i = 0; i < NSEG; i++) begin
        lfsr_r[i] <= lfsr_step(lfsr_r[i]);
      end
    end else begin
      for (int i = 0; i < NSEG; i++) begin
        lfsr_r[i] <= lfsr_r[i];
      end
    end
  end

  // Child registers and saturating crossover-event counter, updated only on accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      child0_r      <= '0;
      child1_r      <= '0;
      xover_count_r <= 16'h0000;
    end else if (accept_s) begin
      child0_r <= nxt0_s;
      child1_r <= nxt1_s;
      if ((mask_s != '0) && (xover_count_r != 16'hFFFF)) begin
        xover_count_r <= xover_count_r + 16'h0001;
      end else begin
        xover_count_r <= xover_count_r;
      end
    end else begin
      child0_r      <= child0_r;
      child1_r      <= child1_r;
      xover_count_r <= xover_count_r;
    end
  end
endmodule

// File: tb/tb_ga_crossover_unit.sv
// Scoreboard bench for ga_crossover_unit: a reference model predicts children on every accept,
// and the monitor compares them when the DUT presents its output.
module tb_ga_crossover_unit;
  localparam int          GENE_W = 32;
  localparam int          SEG_W  = 8;
  localparam int          NSEG   = GENE_W / SEG_W;
  localparam int          LG     = 2;
  localparam logic [15:0] SEED   = 16'hACE1;

  typedef struct packed {
    logic [GENE_W-1:0] c0;
    logic [GENE_W-1:0] c1;
    logic [GENE_W-1:0] p0;
    logic [GENE_W-1:0] p1;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        seed_load;
  logic [15:0] seed_in;
  logic [15:0] xover_count;

  ga_crossover_unit_if #(.GENE_W(GENE_W)) bus ();

  ga_crossover_unit #(.GENE_W(GENE_W), .SEG_W(SEG_W), .SEED(SEED)) dut (
    .clk(clk), .rst(rst), .seed_load(seed_load), .seed_in(seed_in),
    .xover_count(xover_count), .bus(bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  logic chk_en   = 1'b1;
  logic shape_en = 1'b0;
  logic cap_en   = 1'b0;

  exp_t              exp_q[$];
  logic [GENE_W-1:0] cap_q[$];

  logic [NSEG-1:0][15:0] m_lfsr;
  logic                  m_ov;
  logic [15:0]           m_count;
  logic                  m_acc;
  logic [NSEG-1:0]       m_mask;
  exp_t                  m_exp;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%08h exp=%08h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] tb_seed(input logic [15:0] base, input int i);
    logic [15:0] s;
    s = base ^ 16'(i * 32'h1F35);
    return (s == 16'h0000) ? 16'h0001 : s;
  endfunction

  function automatic logic [15:0] tb_step(input logic [15:0] l);
    return {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
  endfunction

  function automatic logic tb_hit(input logic [7:0] x, input logic [7:0] p);
    return (p == 8'hFF) ? 1'b1 : (x < p);
  endfunction

  function automatic logic [NSEG-1:0] tb_mask(input logic [NSEG-1:0][15:0] l, input logic [1:0] md,
                                              input logic [7:0] p);
    logic [NSEG-1:0] m;
    int c0, c1, lo, hi;
    logic h2;
    m  = '0;
    c0 = int'(l[0][LG-1:0]);
    c1 = int'(l[1][LG-1:0]);
    lo = (c0 < c1) ? c0 : c1;
    hi = (c0 < c1) ? c1 : c0;
    h2 = tb_hit(l[2][7:0], p);
    for (int i = 0; i < NSEG; i++) begin
      case (md)
        2'd0:    m[i] = tb_hit(l[i][7:0], p);
        2'd1:    m[i] = h2 && (i >= c0);
        2'd2:    m[i] = h2 && (i >= lo) && (i < hi);
        default: m[i] = 1'b0;
      endcase
    end
    return m;
  endfunction

  function automatic exp_t build_exp(input logic [NSEG-1:0] m, input logic b,
                                     input logic [GENE_W-1:0] p0, input logic [GENE_W-1:0] p1);
    exp_t e;
    logic [GENE_W-1:0] a, o;
    a = b ? p1 : p0;
    o = b ? p0 : p1;
    e.p0 = p0;
    e.p1 = p1;
    for (int i = 0; i < NSEG; i++) begin
      e.c0[i*SEG_W +: SEG_W] = m[i] ? o[i*SEG_W +: SEG_W] : a[i*SEG_W +: SEG_W];
      e.c1[i*SEG_W +: SEG_W] = m[i] ? a[i*SEG_W +: SEG_W] : o[i*SEG_W +: SEG_W];
    end
    return e;
  endfunction

  // Swapped segments must be whole segments forming at most one contiguous run.
  function automatic logic shape_ok(input logic [GENE_W-1:0] x, input logic [GENE_W-1:0] d);
    logic ok, prev, sw;
    int runs;
    ok = 1'b1; prev = 1'b0; runs = 0;
    for (int i = 0; i < NSEG; i++) begin
      sw = (x[i*SEG_W +: SEG_W] != '0);
      if (sw && (x[i*SEG_W +: SEG_W] != d[i*SEG_W +: SEG_W])) ok = 1'b0;
      if (sw && !prev) runs++;
      prev = sw;
    end
    return ok && (runs <= 1);
  endfunction

  assign m_acc = bus.in_valid && (!m_ov || bus.out_ready);
  assign m_mask = tb_mask(m_lfsr, bus.mode, bus.co_prob);
  assign m_exp = build_exp(m_mask, bus.bias, bus.parent0, bus.parent1);

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NSEG; i++) m_lfsr[i] <= tb_seed(SEED, i);
      m_ov    <= 1'b0;
      m_count <= 16'h0000;
      exp_q.delete();
    end else begin
      if (m_acc) begin
        exp_q.push_back(m_exp);
        if ((m_mask != '0) && (m_count != 16'hFFFF)) m_count <= m_count + 16'd1;
      end
      for (int i = 0; i < NSEG; i++) begin
        if (seed_load) m_lfsr[i] <= tb_seed(seed_in, i);
        else if (m_acc) m_lfsr[i] <= tb_step(m_lfsr[i]);
      end
      if (m_acc) m_ov <= 1'b1;
      else if (bus.out_ready) m_ov <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (chk_en) begin
        check_eq("in_ready", 32'(bus.in_ready), 32'(!m_ov || bus.out_ready));
        check_eq("out_valid", 32'(bus.out_valid), 32'(m_ov));
        check_eq("xover_count", 32'(xover_count), 32'(m_count));
      end
      if (bus.out_valid) begin
        if (exp_q.size() == 0) begin
          check_eq("sb_underflow", 32'(exp_q.size()), 32'd1);
        end else begin
          if (chk_en) begin
            check_eq("child0", bus.child0, exp_q[0].c0);
            check_eq("child1", bus.child1, exp_q[0].c1);
            if (shape_en)
              check_eq("twopoint_shape",
                       32'(shape_ok(bus.child0 ^ exp_q[0].p0, exp_q[0].p0 ^ exp_q[0].p1)), 32'd1);
          end
          if (cap_en && bus.out_ready) cap_q.push_back(bus.child0);
          if (bus.out_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic send(input logic [1:0] md, input logic [7:0] cp, input logic b,
                      input logic [GENE_W-1:0] p0, input logic [GENE_W-1:0] p1, input logic rnd_rdy);
    logic got;
    got = 1'b0;
    bus.mode = md; bus.co_prob = cp; bus.bias = b;
    bus.parent0 = p0; bus.parent1 = p1; bus.in_valid = 1'b1;
    for (int n = 0; n < 64 && !got; n++) begin
      if (rnd_rdy) bus.out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      got = m_acc;
      @(posedge clk);
      #2;
    end
    if (!got) check_eq("accept_timeout", 32'(got), 32'd1);
  endtask

  task automatic check_reset_state();
    check_eq("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check_eq("rst_child0", bus.child0, 32'h0000_0000);
    check_eq("rst_child1", bus.child1, 32'h0000_0000);
    check_eq("rst_count", 32'(xover_count), 32'd0);
    check_eq("rst_in_ready", 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    #10_000_000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "simulation watchdog");
  end

  initial begin
    logic [GENE_W-1:0] p0, d;
    logic [GENE_W-1:0] rp0[16];
    logic [GENE_W-1:0] rp1[16];
    rst = 1'b1; seed_load = 1'b0; seed_in = 16'h0000;
    bus.mode = 2'd0; bus.co_prob = 8'h00; bus.bias = 1'b0; bus.in_valid = 1'b0;
    bus.parent0 = '0; bus.parent1 = '0; bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    @(negedge clk);
    check_reset_state();
    @(posedge clk);
    #2;

    send(2'd0, 8'h00, 1'b0, 32'hAAAA_AAAA, 32'h5555_5555, 1'b0);
    check_eq("never_c0", bus.child0, 32'hAAAA_AAAA);
    check_eq("never_c1", bus.child1, 32'h5555_5555);
    check_eq("never_cnt", 32'(xover_count), 32'd0);
    send(2'd0, 8'hFF, 1'b0, 32'hAAAA_AAAA, 32'h5555_5555, 1'b0);
    check_eq("always_c0", bus.child0, 32'h5555_5555);
    check_eq("always_c1", bus.child1, 32'hAAAA_AAAA);
    check_eq("always_cnt", 32'(xover_count), 32'd1);
    send(2'd3, 8'hFF, 1'b1, 32'hAAAA_AAAA, 32'h5555_5555, 1'b0);
    check_eq("pass_bias_c0", bus.child0, 32'h5555_5555);
    check_eq("pass_bias_c1", bus.child1, 32'hAAAA_AAAA);
    check_eq("pass_bias_cnt", 32'(xover_count), 32'd1);
    idle(2);

    bus.out_ready = 1'b0;
    send(2'd0, 8'hFF, 1'b0, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0);
    bus.mode = 2'd1; bus.parent0 = 32'h0F0F_0F0F; bus.parent1 = 32'hF0F0_F0F0;
    repeat (3) begin
      @(negedge clk);
      check_eq("bp_in_ready", 32'(bus.in_ready), 32'd0);
      check_eq("bp_hold_c0", bus.child0, 32'h9ABC_DEF0);
      check_eq("bp_hold_c1", bus.child1, 32'h1234_5678);
    end
    @(posedge clk);
    #2;
    bus.out_ready = 1'b1;
    @(negedge clk);
    check_eq("bp_release", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #2;
    idle(2);

    shape_en = 1'b1;
    for (int k = 0; k < 64; k++) begin
      p0 = $urandom;
      d  = $urandom | 32'h0101_0101;
      send(2'd2, 8'hFF, 1'b0, p0, p0 ^ d, 1'b0);
    end
    idle(2);
    shape_en = 1'b0;

    for (int k = 0; k < 40; k++)
      send(2'($urandom_range(0, 3)), 8'($urandom), 1'($urandom_range(0, 1)), $urandom, $urandom, 1'b1);
    bus.out_ready = 1'b1;
    idle(2);
    seed_in = 16'hBEEF; seed_load = 1'b1;
    send(2'd0, 8'h80, 1'b0, $urandom, $urandom, 1'b0);
    seed_load = 1'b0;
    send(2'd1, 8'hC0, 1'b1, $urandom, $urandom, 1'b0);
    idle(2);

    for (int k = 0; k < 16; k++) begin
      rp0[k] = $urandom;
      rp1[k] = $urandom;
    end
    cap_q.delete();
    cap_en = 1'b1;
    for (int r = 0; r < 2; r++) begin
      seed_in = 16'h1234; seed_load = 1'b1;
      idle(1);
      seed_load = 1'b0;
      for (int k = 0; k < 16; k++) send(2'd0, 8'h80, 1'b0, rp0[k], rp1[k], 1'b0);
      idle(3);
    end
    cap_en = 1'b0;
    check_eq("reseed_len", 32'(cap_q.size()), 32'd32);
    if (cap_q.size() == 32)
      for (int k = 0; k < 16; k++) check_eq("reseed_repeat", cap_q[k+16], cap_q[k]);

    bus.out_ready = 1'b0;
    send(2'd0, 8'hFF, 1'b0, 32'hDEAD_BEEF, 32'hCAFE_F00D, 1'b0);
    bus.in_valid = 1'b0;
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    check_reset_state();
    @(posedge clk);
    #2;

    chk_en = 1'b0;
    bus.mode = 2'd0; bus.co_prob = 8'hFF; bus.bias = 1'b0;
    bus.parent0 = 32'hFFFF_0000; bus.parent1 = 32'h0000_FFFF;
    bus.in_valid = 1'b1;
    repeat (65534) @(posedge clk);
    #2;
    idle(2);
    chk_en = 1'b1;
    check_eq("sat_preload", 32'(xover_count), 32'h0000_FFFE);
    for (int k = 0; k < 3; k++) send(2'd0, 8'hFF, 1'b0, $urandom, $urandom, 1'b0);
    idle(2);
    check_eq("sat_final", 32'(xover_count), 32'h0000_FFFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
